vec_mem_sequencer: RTL and testbench

//  Parametrised memory-stage sequencer for the vector pipeline. Serialises LANES-wide vector loads/stores

---
 rtl/vec_mem_sequencer.sv | 154 +++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// Vector memory-stage sequencer: serialises vector loads/stores onto one RAM port.
// Optional signed lane stride via `define VMEM_STRIDE_EN (unit stride otherwise).
module vec_mem_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic                             req_vector,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_sdata,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] req_vdata,
`ifdef VMEM_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]            req_stride,
`endif
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             mem_we,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [DATA_WIDTH-1:0]            sload_data,
  output logic [LANES-1:0][DATA_WIDTH-1:0] vload_data,
  output logic                             vload_valid,
  output logic                             stall,
  output logic                             busy
);

  localparam int CW = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic [CW-1:0]                    r_cnt;
  logic [ADDR_WIDTH-1:0]            r_addr;
  logic [LANES-1:0][DATA_WIDTH-1:0] r_vdata;
  logic [LANES-1:0][DATA_WIDTH-1:0] r_vload;
  logic                             r_pend;
  logic [CW-1:0]                    r_pidx;
  logic [ADDR_WIDTH-1:0]            w_stride;
  logic                             w_last;
  logic                             w_accept;

`ifdef VMEM_STRIDE_EN
  logic [ADDR_WIDTH-1:0]            r_stride;
  assign w_stride = r_stride;
`else
  assign w_stride = ADDR_WIDTH'(1);
`endif

  assign w_last      = (r_cnt == CW'(LANES - 1));
  assign w_accept    = (r_state == S_IDLE) & req_valid & req_vector;
  assign busy        = (r_state != S_IDLE);
  assign vload_valid = (r_state == S_DONE);
  assign vload_data  = r_vload;
  assign sload_data  = mem_rdata;

  // Next-state and RAM/stall outputs; IDLE outputs are masked while reset is held
  always_comb begin
    w_next    = r_state;
    mem_addr  = req_addr;
    mem_wdata = req_sdata;
    mem_we    = 1'b0;
    stall     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        mem_we = rst & req_valid & req_write & ~req_vector;
        stall  = rst & w_accept;
        if (w_accept) begin
          w_next = req_write ? S_STORE : S_LOAD;
        end
      end
      S_STORE: begin
        mem_addr  = r_addr;
        mem_wdata = r_vdata[r_cnt];
        mem_we    = 1'b1;
        stall     = ~w_last;
        if (w_last) begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        mem_addr = r_addr;
        stall    = 1'b1;
        if (w_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture, lane walk and load-lane collection one cycle after issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_vdata <= '0;
      r_vload <= '0;
      r_pend  <= 1'b0;
      r_pidx  <= '0;
`ifdef VMEM_STRIDE_EN
      r_stride <= '0;
`endif
    end else begin
      r_pend <= 1'b0;
      if (r_pend) begin
        r_vload[r_pidx] <= mem_rdata;
      end
      if (w_accept) begin
        r_addr  <= req_addr;
        r_vdata <= req_vdata;
        r_cnt   <= '0;
`ifdef VMEM_STRIDE_EN
        r_stride <= req_stride;
`endif
      end else if (r_state == S_STORE || r_state == S_LOAD) begin
        r_addr <= r_addr + w_stride;
        r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
        if (r_state == S_LOAD) begin
          r_pend <= 1'b1;
          r_pidx <= r_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Randomised self-checking bench for vec_mem_sequencer.
// Reference RAM model plus per-lane address arithmetic from the op rules.
module tb_vec_mem_sequencer;

  localparam int DW = 16;
  localparam int L  = 16;
  localparam int AW = 19;

  typedef logic [L-1:0][DW-1:0] vec_t;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_vector = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_sdata = '0;
  vec_t          req_vdata = '0;
`ifdef VMEM_STRIDE_EN
  logic [AW-1:0] req_stride = AW'(1);
`endif
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] sload_data;
  vec_t          vload_data;
  logic          vload_valid;
  logic          stall;
  logic          busy;

  logic [DW-1:0] ram   [logic [AW-1:0]];
  logic [DW-1:0] model [logic [AW-1:0]];
  logic [DW-1:0] next_rd = '0;
  wr_t           wq[$];

  int n_tests = 0;
  int n_fail  = 0;

  vec_mem_sequencer #(
    .DATA_WIDTH(DW),
    .LANES(L),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_vector(req_vector),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_sdata(req_sdata),
    .req_vdata(req_vdata),
`ifdef VMEM_STRIDE_EN
    .req_stride(req_stride),
`endif
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .sload_data(sload_data),
    .vload_data(vload_data),
    .vload_valid(vload_valid),
    .stall(stall),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM: read-first, one cycle latency; writes logged for checking
  always @(negedge clk) begin
    next_rd = ram.exists(mem_addr) ? ram[mem_addr] : '0;
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      wq.push_back('{a: mem_addr, d: mem_wdata});
    end
  end

  always @(posedge clk) mem_rdata <= next_rd;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] base,
                                              input int stride, input int k);
    return AW'(int'(base) + k * stride);
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model.exists(a) ? model[a] : '0;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < L; k++) v[k] = DW'($urandom);
    return v;
  endfunction

  // Drives a vector request, holding it while stall is high
  task automatic run_vec(input bit wr, input logic [AW-1:0] base,
                         input vec_t vd, output int sc, output bit gv,
                         output vec_t vl, output bit ok);
    req_valid = 1'b1; req_vector = 1'b1; req_write = wr;
    req_addr = base; req_vdata = vd;
    sc = 0; gv = 1'b0; vl = '0; ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (vload_valid) begin gv = 1'b1; vl = vload_data; end
      if (!stall) begin ok = 1'b1; break; end
      sc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_vector = 1'b0; req_write = 1'b0;
    req_addr = AW'($urandom); req_vdata = rand_vec();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", stall); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_tests++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", mem_we); end
    n_tests++;
    if (vload_valid !== 1'b0) begin n_fail++; $display("FAIL rst_vvalid: got %b expected 0", vload_valid); end
    n_tests++;
    if (vload_data !== '0) begin n_fail++; $display("FAIL rst_vdata: got %h expected 0", vload_data); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_scalar();
    wq.delete();
    req_valid = 1'b1; req_vector = 1'b0; req_write = 1'b1;
    req_addr = AW'('h100); req_sdata = 16'hBEEF;
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== AW'('h100) || mem_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL sc_store: got we=%b a=%h d=%h expected 1 100 beef", mem_we, mem_addr, mem_wdata);
    end
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL sc_store_stall: got %b expected 0", stall); end
    model[AW'('h100)] = 16'hBEEF;
    @(posedge clk); #1;
    req_write = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b0 || stall !== 1'b0 || mem_addr !== AW'('h100)) begin
      n_fail++;
      $display("FAIL sc_load_issue: got we=%b st=%b a=%h expected 0 0 100", mem_we, stall, mem_addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sload_data !== 16'hBEEF) begin n_fail++; $display("FAIL sc_load_data: got %h expected beef", sload_data); end
    n_tests++;
    if (wq.size() != 1) begin n_fail++; $display("FAIL sc_wcount: got %0d expected 1", wq.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_vec_store(input logic [AW-1:0] base, input int stride,
                                input vec_t vd, input string nm);
    int sc; bit gv; bit ok; vec_t vl;
    wq.delete();
    run_vec(1'b1, base, vd, sc, gv, vl, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: stall never dropped", nm); end
    n_tests++;
    if (sc != L) begin n_fail++; $display("FAIL %s_stall: got %0d cycles expected %0d", nm, sc, L); end
    n_tests++;
    if (wq.size() != L) begin
      n_fail++;
      $display("FAIL %s_wcount: got %0d expected %0d", nm, wq.size(), L);
    end else begin
      for (int k = 0; k < L; k++) begin
        n_tests++;
        if (wq[k].a !== lane_addr(base, stride, k) || wq[k].d !== vd[k]) begin
          n_fail++;
          $display("FAIL %s_lane%0d: got %h/%h expected %h/%h", nm, k,
                   wq[k].a, wq[k].d, lane_addr(base, stride, k), vd[k]);
        end
      end
    end
    for (int k = 0; k < L; k++) model[lane_addr(base, stride, k)] = vd[k];
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy got %b expected 0", nm, busy); end
  endtask

  task automatic test_vec_load(input logic [AW-1:0] base, input int stride,
                               input string nm);
    int sc; bit gv; bit ok; vec_t vl; vec_t ex;
    for (int k = 0; k < L; k++) ex[k] = model_rd(lane_addr(base, stride, k));
    wq.delete();
    run_vec(1'b0, base, rand_vec(), sc, gv, vl, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: stall never dropped", nm); end
    n_tests++;
    if (sc != L + 2) begin n_fail++; $display("FAIL %s_stall: got %0d cycles expected %0d", nm, sc, L + 2); end
    n_tests++;
    if (!gv) begin n_fail++; $display("FAIL %s_valid: vload_valid got 0 expected 1", nm); end
    n_tests++;
    if (vl !== ex) begin n_fail++; $display("FAIL %s_data: got %h expected %h", nm, vl, ex); end
    n_tests++;
    if (wq.size() != 0) begin n_fail++; $display("FAIL %s_nowrite: got %0d writes expected 0", nm, wq.size()); end
    n_tests++;
    if (vload_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: got vv=%b busy=%b expected 0 0", nm, vload_valid, busy);
    end
    req_valid = 1'b1; req_vector = 1'b0; req_write = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++;
    if (vload_data !== ex) begin n_fail++; $display("FAIL %s_hold: got %h expected %h", nm, vload_data, ex); end
  endtask

  task automatic test_fixed();
    vec_t vd;
    for (int k = 0; k < L; k++) vd[k] = DW'(k + 1);
    test_vec_store(AW'('h200), 1, vd, "vst200");
    test_vec_load(AW'('h200), 1, "vld200");
  endtask

  task automatic test_wrap();
    test_vec_store(AW'('h7FFFE), 1, rand_vec(), "wrap_st");
    test_vec_load(AW'('h7FFFE), 1, "wrap_ld");
  endtask

  task automatic test_midload_reset();
    req_valid = 1'b1; req_vector = 1'b1; req_write = 1'b0;
    req_addr = AW'('h200);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ctl: got stall=%b busy=%b expected 0 0", stall, busy);
    end
    n_tests++;
    if (vload_data !== '0) begin n_fail++; $display("FAIL midrst_vdata: got %h expected 0", vload_data); end
    req_valid = 1'b0; req_vector = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: busy got %b expected 0", busy); end
    test_vec_load(AW'('h200), 1, "postrst_ld");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] b;
    for (int i = 0; i < 6; i++) begin
      b = AW'($urandom);
      test_vec_store(b, 1, rand_vec(), "b2b_st");
      test_vec_load(b, 1, "b2b_ld");
      test_vec_load(AW'($urandom), 1, "rnd_ld");
    end
  endtask

`ifdef VMEM_STRIDE_EN
  task automatic test_stride();
    req_stride = AW'('h7FFFE);
    test_vec_store(AW'('h40), -2, rand_vec(), "strm2_st");
    test_vec_load(AW'('h40), -2, "strm2_ld");
    req_stride = '0;
    test_vec_store(AW'('h40), 0, rand_vec(), "str0_st");
    test_vec_load(AW'('h40), 0, "str0_ld");
    req_stride = AW'(1);
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_scalar();
    test_fixed();
    test_wrap();
    test_midload_reset();
    test_back_to_back();
`ifdef VMEM_STRIDE_EN
    test_stride();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
